exec_stage_mdu: RTL and testbench

//  Parametrised EX stage: ID/EX pipeline register with stall/flush/valid, A/B forwarding, ALU and an

---
 rtl/exec_stage_mdu.sv | 221 ++++++++++++++++++++++
 tb/tb_exec_stage_mdu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_mdu.sv
// ============================================================================
//  Module      : exec_stage_mdu
//  Description : EX stage with ID/EX register, operand forwarding, ALU and an
//                iterative radix-2 multiply/divide unit holding HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_stage_mdu #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          d_valid,
  input  logic [3:0]    d_alu_ctrl,
  input  logic          d_alu_src,
  input  logic          d_reg_write,
  input  logic          d_mem_to_reg,
  input  logic          d_mem_wr,
  input  logic [2:0]    d_md_op,
  input  logic [W-1:0]  d_bus_a,
  input  logic [W-1:0]  d_bus_b,
  input  logic [W-1:0]  d_imm,
  input  logic [RW-1:0] d_rw,
  input  logic [1:0]    fwd_sel_a,
  input  logic [1:0]    fwd_sel_b,
  input  logic [W-1:0]  fwd_mem,
  input  logic [W-1:0]  fwd_wb,
  output logic          q_valid,
  output logic          q_reg_write,
  output logic          q_mem_to_reg,
  output logic          q_mem_wr,
  output logic [RW-1:0] q_rw,
  output logic [W-1:0]  alu_out,
  output logic [W-1:0]  bus_b_out,
  output logic          md_busy,
  output logic [W-1:0]  hi,
  output logic [W-1:0]  lo
);

  localparam int SW = $clog2(W);
  localparam int CW = SW + 1;

  localparam logic [2:0] c_MULT  = 3'd1;
  localparam logic [2:0] c_MULTU = 3'd2;
  localparam logic [2:0] c_DIV   = 3'd3;
  localparam logic [2:0] c_DIVU  = 3'd4;
  localparam logic [2:0] c_MFHI  = 3'd5;
  localparam logic [2:0] c_MFLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  logic          r_valid, r_alu_src, r_reg_write, r_mem_to_reg, r_mem_wr;
  logic [3:0]    r_alu_ctrl;
  logic [2:0]    r_md_op;
  logic [W-1:0]  r_bus_a, r_bus_b, r_imm;
  logic [RW-1:0] r_rw;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_mc, r_wh, r_wl, r_hi, r_lo;
  logic          r_sa, r_sb, r_div, r_bz;

  logic          w_hold, w_md_start, w_signed_op;
  logic [W-1:0]  w_op_a, w_op_b, w_alu_b, w_alu_res, w_abs_a, w_abs_b;
  logic [SW-1:0] w_shamt;
  logic [W:0]    w_sum, w_trial, w_diff;
  logic [W-1:0]  w_step_hi, w_step_lo;
  logic [2*W-1:0] w_prod;

  assign w_hold = stall_in | md_busy;

  // ID/EX register: flush beats hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      r_valid <= 1'b0; r_alu_ctrl <= '0; r_alu_src <= 1'b0; r_reg_write <= 1'b0;
      r_mem_to_reg <= 1'b0; r_mem_wr <= 1'b0; r_md_op <= '0;
      r_bus_a <= '0; r_bus_b <= '0; r_imm <= '0; r_rw <= '0;
    end else if (!w_hold) begin
      r_valid <= d_valid; r_alu_ctrl <= d_alu_ctrl; r_alu_src <= d_alu_src;
      r_reg_write <= d_reg_write; r_mem_to_reg <= d_mem_to_reg; r_mem_wr <= d_mem_wr;
      r_md_op <= d_md_op; r_bus_a <= d_bus_a; r_bus_b <= d_bus_b;
      r_imm <= d_imm; r_rw <= d_rw;
    end
  end

  always_comb begin
    case (fwd_sel_a)
      2'd0:    w_op_a = r_bus_a;
      2'd1:    w_op_a = fwd_mem;
      2'd2:    w_op_a = fwd_wb;
      default: w_op_a = '0;
    endcase
    case (fwd_sel_b)
      2'd0:    w_op_b = r_bus_b;
      2'd1:    w_op_b = fwd_mem;
      2'd2:    w_op_b = fwd_wb;
      default: w_op_b = '0;
    endcase
  end

  assign w_alu_b = r_alu_src ? r_imm : w_op_b;
  assign w_shamt = w_op_a[SW-1:0];

  always_comb begin
    w_alu_res = '0;
    case (r_alu_ctrl)
      4'd0:  w_alu_res = w_op_a + w_alu_b;
      4'd1:  w_alu_res = w_op_a - w_alu_b;
      4'd2:  w_alu_res = w_op_a & w_alu_b;
      4'd3:  w_alu_res = w_op_a | w_alu_b;
      4'd4:  w_alu_res = w_op_a ^ w_alu_b;
      4'd5:  w_alu_res = ~(w_op_a | w_alu_b);
      4'd6:  w_alu_res = {{(W-1){1'b0}}, ($signed(w_op_a) < $signed(w_alu_b))};
      4'd7:  w_alu_res = {{(W-1){1'b0}}, (w_op_a < w_alu_b)};
      4'd8:  w_alu_res = w_alu_b << w_shamt;
      4'd9:  w_alu_res = w_alu_b >> w_shamt;
      4'd10: w_alu_res = $signed(w_alu_b) >>> w_shamt;
      4'd11: w_alu_res = w_alu_b << (W/2);
      default: w_alu_res = '0;
    endcase
  end

  assign alu_out      = (r_md_op == c_MFHI) ? r_hi :
                        (r_md_op == c_MFLO) ? r_lo : w_alu_res;
  assign bus_b_out    = w_op_b;
  assign q_valid      = r_valid;
  assign q_reg_write  = r_reg_write & r_valid;
  assign q_mem_wr     = r_mem_wr & r_valid;
  assign q_mem_to_reg = r_mem_to_reg;
  assign q_rw         = r_rw;
  assign hi           = r_hi;
  assign lo           = r_lo;

  assign w_md_start  = r_valid && (r_md_op >= c_MULT) && (r_md_op <= c_DIVU);
  assign w_signed_op = (r_md_op == c_MULT) || (r_md_op == c_DIV);
  assign w_abs_a     = (w_signed_op && w_op_a[W-1]) ? (~w_op_a + 1'b1) : w_op_a;
  assign w_abs_b     = (w_signed_op && w_op_b[W-1]) ? (~w_op_b + 1'b1) : w_op_b;

  always_comb begin
    w_next  = r_state;
    md_busy = 1'b0;
    case (r_state)
      S_IDLE: if (w_md_start) begin
        md_busy = 1'b1;
        w_next  = S_RUN;
      end
      S_RUN: begin
        md_busy = 1'b1;
        if (r_cnt == '0) w_next = S_DONE;
      end
      S_DONE: if (!stall_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Mult: {acc, multiplier} shifts right; div: {rem, dividend} shifts left
  assign w_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_mc} : '0);
  assign w_trial = {r_wh, r_wl[W-1]};
  assign w_diff  = w_trial - {1'b0, r_mc};

  always_comb begin
    if (r_div) begin
      if (w_trial >= {1'b0, r_mc}) begin
        w_step_hi = w_diff[W-1:0];
        w_step_lo = {r_wl[W-2:0], 1'b1};
      end else begin
        w_step_hi = w_trial[W-1:0];
        w_step_lo = {r_wl[W-2:0], 1'b0};
      end
    end else begin
      w_step_hi = w_sum[W:1];
      w_step_lo = {w_sum[0], r_wl[W-1:1]};
    end
    w_prod = {w_step_hi, w_step_lo};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE; r_cnt <= '0; r_mc <= '0; r_wh <= '0; r_wl <= '0;
      r_sa <= 1'b0; r_sb <= 1'b0; r_div <= 1'b0; r_bz <= 1'b0;
      r_hi <= '0; r_lo <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_md_start) begin
        r_div <= (r_md_op == c_DIV) || (r_md_op == c_DIVU);
        r_sa  <= w_signed_op & w_op_a[W-1];
        r_sb  <= w_signed_op & w_op_b[W-1];
        r_bz  <= (w_op_b == '0);
        r_cnt <= CW'(W-1);
        r_wh  <= '0;
        if ((r_md_op == c_DIV) || (r_md_op == c_DIVU)) begin
          r_mc <= w_abs_b; r_wl <= w_abs_a;
        end else begin
          r_mc <= w_abs_a; r_wl <= w_abs_b;
        end
      end else if (r_state == S_RUN) begin
        r_wh  <= w_step_hi;
        r_wl  <= w_step_lo;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          if (!r_div) begin
            {r_hi, r_lo} <= (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
          end else begin
            r_hi <= r_sa ? (~w_step_hi + 1'b1) : w_step_hi;
            if (r_bz)
              r_lo <= '1;
            else
              r_lo <= (r_sa ^ r_sb) ? (~w_step_lo + 1'b1) : w_step_lo;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_stage_mdu.sv
// ============================================================================
//  Module      : tb_exec_stage_mdu
//  Description : Directed bench for exec_stage_mdu with a cycle-level reference
//                model compared every cycle plus literal pinned expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_stage_mdu;
  localparam int W  = 32;
  localparam int RW = 5;

  logic          clk = 1'b0, rst_n = 1'b1, stall_in = 1'b0, flush = 1'b0;
  logic          d_valid = 1'b0, d_alu_src = 1'b0, d_reg_write = 1'b0;
  logic          d_mem_to_reg = 1'b0, d_mem_wr = 1'b0;
  logic [3:0]    d_alu_ctrl = '0;
  logic [2:0]    d_md_op = '0;
  logic [W-1:0]  d_bus_a = '0, d_bus_b = '0, d_imm = '0, fwd_mem = '0, fwd_wb = '0;
  logic [RW-1:0] d_rw = '0;
  logic [1:0]    fwd_sel_a = '0, fwd_sel_b = '0;
  logic          q_valid, q_reg_write, q_mem_to_reg, q_mem_wr, md_busy;
  logic [RW-1:0] q_rw;
  logic [W-1:0]  alu_out, bus_b_out, hi, lo;

  exec_stage_mdu #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .d_valid(d_valid), .d_alu_ctrl(d_alu_ctrl), .d_alu_src(d_alu_src),
    .d_reg_write(d_reg_write), .d_mem_to_reg(d_mem_to_reg), .d_mem_wr(d_mem_wr),
    .d_md_op(d_md_op), .d_bus_a(d_bus_a), .d_bus_b(d_bus_b), .d_imm(d_imm),
    .d_rw(d_rw), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .q_valid(q_valid), .q_reg_write(q_reg_write), .q_mem_to_reg(q_mem_to_reg),
    .q_mem_wr(q_mem_wr), .q_rw(q_rw), .alu_out(alu_out), .bus_b_out(bus_b_out),
    .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ID/EX contents, HI/LO and remaining MDU busy cycles
  logic          m_valid, m_src, m_rwr, m_m2r, m_mwr, m_served;
  logic [3:0]    m_ctrl;
  logic [2:0]    m_op;
  logic [W-1:0]  m_a, m_b, m_imm, m_hi, m_lo;
  logic [RW-1:0] m_rw;
  logic [63:0]   m_res;
  int            m_left;

  function automatic logic [W-1:0] fwd(input logic [1:0] s, input logic [W-1:0] r);
    case (s)
      2'd0: return r;
      2'd1: return fwd_mem;
      2'd2: return fwd_wb;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] opa();  return fwd(fwd_sel_a, m_a); endfunction
  function automatic logic [W-1:0] opb();  return fwd(fwd_sel_b, m_b); endfunction

  function automatic logic exp_busy();
    return (m_left > 0) || (m_valid && m_op >= 3'd1 && m_op <= 3'd4 && !m_served);
  endfunction

  function automatic logic [W-1:0] exp_alu();
    logic [W-1:0] a, b;
    int sh;
    a = opa();
    b = m_src ? m_imm : opb();
    sh = int'(a[4:0]);
    if (m_op == 3'd5) return m_hi;
    if (m_op == 3'd6) return m_lo;
    case (m_ctrl)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return $signed(b) >>> sh;
      4'd11: return b << 16;
      default: return '0;
    endcase
  endfunction

  // Returns {hi, lo} computed with plain wide arithmetic
  function automatic logic [63:0] mdu_calc(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [63:0] p, q, r;
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd3: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_src <= 0; m_rwr <= 0; m_m2r <= 0; m_mwr <= 0; m_ctrl <= 0;
      m_op <= 0; m_a <= 0; m_b <= 0; m_imm <= 0; m_rw <= 0;
      m_hi <= 0; m_lo <= 0; m_left <= 0; m_served <= 0; m_res <= 0;
    end else begin
      if (m_left == 0 && exp_busy()) begin
        m_res    <= mdu_calc(m_op, opa(), opb());
        m_left   <= W;
        m_served <= 1'b1;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; end
      end
      if (flush) begin
        m_valid <= 0; m_src <= 0; m_rwr <= 0; m_m2r <= 0; m_mwr <= 0; m_ctrl <= 0;
        m_op <= 0; m_a <= 0; m_b <= 0; m_imm <= 0; m_rw <= 0;
      end else if (!(stall_in || exp_busy())) begin
        m_valid <= d_valid; m_src <= d_alu_src; m_rwr <= d_reg_write; m_m2r <= d_mem_to_reg;
        m_mwr <= d_mem_wr; m_ctrl <= d_alu_ctrl; m_op <= d_md_op; m_a <= d_bus_a;
        m_b <= d_bus_b; m_imm <= d_imm; m_rw <= d_rw; m_served <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("q_valid", q_valid, m_valid);
      chk("q_reg_write", q_reg_write, m_rwr & m_valid);
      chk("q_mem_wr", q_mem_wr, m_mwr & m_valid);
      chk("q_mem_to_reg", q_mem_to_reg, m_m2r);
      chk("q_rw", q_rw, m_rw);
      chk("alu_out", alu_out, exp_alu());
      chk("bus_b_out", bus_b_out, opb());
      chk("md_busy", md_busy, exp_busy());
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setd(input logic [3:0] ctrl, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [RW-1:0] rw);
    d_valid = 1'b1; d_alu_ctrl = ctrl; d_md_op = op; d_bus_a = a; d_bus_b = b;
    d_rw = rw; d_reg_write = 1'b1; d_mem_to_reg = rw[1]; d_mem_wr = rw[0];
    d_alu_src = 1'b0; d_imm = '0;
  endtask

  task automatic bubble_in();
    d_valid = 1'b0; d_md_op = '0; d_reg_write = 1'b0; d_mem_wr = 1'b0; d_mem_to_reg = 1'b0;
  endtask

  // Loads one MDU op and returns the number of cycles md_busy stays high
  task automatic run_mdu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int busy);
    setd(4'd0, op, a, b, 5'd7);
    cyc(1);
    bubble_in();
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (md_busy) busy++;
      else break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b;
    #3 rst_n = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("rst q_valid", q_valid, 0);
    chk("rst md_busy", md_busy, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst alu_out", alu_out, 0);
    cyc(1);
    rst_n = 1'b1;

    fwd_sel_a = 2'd1; fwd_mem = 32'd5;
    setd(4'd0, 3'd0, 32'd100, 32'd7, 5'd3);
    cyc(1);
    @(negedge clk);
    chk("add fwd_mem", alu_out, 32'd12);

    setd(4'd0, 3'd0, 32'd100, 32'd7, 5'd4);
    d_alu_src = 1'b1; d_imm = 32'd1; fwd_sel_b = 2'd2; fwd_wb = 32'd9;
    cyc(1);
    @(negedge clk);
    chk("add imm", alu_out, 32'd6);
    chk("bus_b fwd_wb", bus_b_out, 32'd9);

    stall_in = 1'b1;
    setd(4'd1, 3'd0, 32'd50, 32'd60, 5'd9);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      @(negedge clk);
      chk("stall alu_out", alu_out, 32'd6);
      chk("stall q_rw", q_rw, 5'd4);
    end
    flush = 1'b1;
    cyc(1);
    flush = 1'b0; stall_in = 1'b0;
    @(negedge clk);
    chk("flush q_valid", q_valid, 0);
    chk("flush q_reg_write", q_reg_write, 0);

    fwd_sel_a = 2'd0; fwd_sel_b = 2'd0;
    run_mdu(3'd1, -32'sd3, 32'd5, b);
    chk("mult busy cycles", b, 33);
    chk("mult hi", hi, 32'hFFFF_FFFF);
    chk("mult lo", lo, 32'hFFFF_FFF1);
    run_mdu(3'd2, -32'sd3, 32'd5, b);
    chk("multu hi", hi, 32'd4);
    chk("multu lo", lo, 32'hFFFF_FFF1);
    run_mdu(3'd3, 32'd7, -32'sd2, b);
    chk("div lo", lo, 32'hFFFF_FFFD);
    chk("div hi", hi, 32'd1);
    run_mdu(3'd4, 32'd7, 32'd0, b);
    chk("divu0 busy cycles", b, 33);
    chk("divu0 lo", lo, 32'hFFFF_FFFF);
    chk("divu0 hi", hi, 32'd7);
    setd(4'd0, 3'd6, 32'd0, 32'd0, 5'd2);
    cyc(1);
    bubble_in();
    @(negedge clk);
    chk("mflo", alu_out, 32'hFFFF_FFFF);

    run_mdu(3'd1, -32'sd6, 32'd7, b);
    stall_in = 1'b1;
    setd(4'd0, 3'd5, 32'd0, 32'd0, 5'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      @(negedge clk);
      chk("done stall busy", md_busy, 0);
      chk("done stall hi", hi, 32'hFFFF_FFFF);
      chk("done stall lo", lo, 32'hFFFF_FFD6);
      chk("done stall alu", alu_out, 32'd1);
    end
    stall_in = 1'b0;
    cyc(1);
    bubble_in();
    @(negedge clk);
    chk("mfhi after done", alu_out, 32'hFFFF_FFFF);

    for (int c = 0; c < 13; c++) begin
      setd(4'(c), 3'd0, 32'd4, 32'h8000_0010, 5'(c));
      cyc(1);
      @(negedge clk);
      if (c == 10) chk("sra", alu_out, 32'hF800_0001);
      if (c == 11) chk("lui", alu_out, 32'h0010_0000);
    end
    setd(4'd1, 3'd0, 32'd123, 32'd1, 5'd5);
    fwd_sel_a = 2'd3;
    cyc(1);
    @(negedge clk);
    chk("fwd zero sub", alu_out, 32'hFFFF_FFFF);
    fwd_sel_a = 2'd0;

    setd(4'd0, 3'd4, 32'd100, 32'd7, 5'd6);
    cyc(1);
    bubble_in();
    repeat (5) @(negedge clk);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    @(negedge clk);
    chk("run flush q_valid", q_valid, 0);
    chk("run flush busy", md_busy, 1);
    b = 0;
    for (int i = 0; i < 100 && md_busy; i++) begin
      @(negedge clk);
      b++;
    end
    chk("run flush done", md_busy, 0);
    chk("run flush hi", hi, 32'd2);
    chk("run flush lo", lo, 32'd14);

    setd(4'd0, 3'd1, -32'sd3, 32'd5, 5'd8);
    cyc(1);
    bubble_in();
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst md_busy", md_busy, 0);
    chk("arst hi", hi, 0);
    chk("arst lo", lo, 0);
    chk("arst q_valid", q_valid, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
